// File: rtl/dp_pkg.sv
// Shared encodings and decode helper for the multicycle MIPS-subset datapath.
package dp_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef struct packed {
        logic    legal;
        logic    is_rtype;
        logic    use_imm;
        logic    is_lw;
        logic    is_sw;
        alu_op_t alu_op;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                c.is_rtype = 1'b1;
                c.legal    = 1'b1;
                case (funct)
                    FN_ADD:  c.alu_op = ALU_ADD;
                    FN_SUB:  c.alu_op = ALU_SUB;
                    FN_AND:  c.alu_op = ALU_AND;
                    FN_OR:   c.alu_op = ALU_OR;
                    FN_SLT:  c.alu_op = ALU_SLT;
                    default: c.legal  = 1'b0;
                endcase
            end
            OP_ADDI: begin
                c.legal   = 1'b1;
                c.use_imm = 1'b1;
            end
            OP_LW: begin
                c.legal   = 1'b1;
                c.use_imm = 1'b1;
                c.is_lw   = 1'b1;
            end
            OP_SW: begin
                c.legal   = 1'b1;
                c.use_imm = 1'b1;
                c.is_sw   = 1'b1;
            end
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Architectural register file: two combinational operand reads, one debug read,
// one synchronous write; register 0 always reads zero and ignores writes.
module reg_file_2r1w #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(REG_COUNT)-1:0] rd_addr_a,
    input  logic [$clog2(REG_COUNT)-1:0] rd_addr_b,
    output logic [DATA_W-1:0]            rd_data_a,
    output logic [DATA_W-1:0]            rd_data_b,
    input  logic [4:0]                   dbg_addr,
    output logic [DATA_W-1:0]            dbg_data,
    input  logic                         wr_en,
    input  logic [$clog2(REG_COUNT)-1:0] wr_addr,
    input  logic [DATA_W-1:0]            wr_data
);
    localparam int AW = $clog2(REG_COUNT);

    logic [DATA_W-1:0] regs [REG_COUNT];
    logic [AW-1:0]     dbg_idx;

    assign dbg_idx = dbg_addr[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
    assign dbg_data  = (dbg_idx == '0)   ? '0 : regs[dbg_idx];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle R-type/ADDI/LW/SW datapath: one instruction per handshake, executed
// through IDLE -> EXEC -> (MEM) -> (WB) with illegal-instruction reporting.
module multicycle_datapath
    import dp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_COUNT  = 32,
    parameter int DMEM_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              done,
    output logic              illegal,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int AW = $clog2(REG_COUNT);
    localparam int MW = $clog2(DMEM_DEPTH);

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] alu_result_q;
    logic              zero_q;
    logic [DATA_W-1:0] mdr_q;

    ctrl_t             ctrl;
    logic [AW-1:0]     rs_idx;
    logic [AW-1:0]     rt_idx;
    logic [AW-1:0]     rd_idx;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_out;

    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [DATA_W-1:0] dmem [DMEM_DEPTH];
    logic [MW-1:0]     mem_idx;
    logic              mem_we;

    assign ctrl    = decode(ir_q[31:26], ir_q[5:0]);
    assign rs_idx  = ir_q[21 +: AW];
    assign rt_idx  = ir_q[16 +: AW];
    assign rd_idx  = ir_q[11 +: AW];
    assign imm_ext = DATA_W'($signed(ir_q[15:0]));

    reg_file_2r1w #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT)
    ) u_reg_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rs_idx),
        .rd_addr_b (rt_idx),
        .rd_data_a (rs_data),
        .rd_data_b (rt_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (rf_we),
        .wr_addr   (rf_waddr),
        .wr_data   (rf_wdata)
    );

    assign op_b = ctrl.use_imm ? imm_ext : rt_data;

    always_comb begin
        alu_out = '0;
        case (ctrl.alu_op)
            ALU_ADD: alu_out = rs_data + op_b;
            ALU_SUB: alu_out = rs_data - op_b;
            ALU_AND: alu_out = rs_data & op_b;
            ALU_OR:  alu_out = rs_data | op_b;
            ALU_SLT: alu_out = DATA_W'($signed(rs_data) < $signed(op_b));
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (instr_valid) state_d = S_EXEC;
            S_EXEC: begin
                if (!ctrl.legal) begin
                    state_d = S_IDLE;
                end else if (ctrl.is_lw || ctrl.is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM:   state_d = ctrl.is_sw ? S_IDLE : S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_IDLE:  instr_ready = 1'b1;
            S_EXEC:  illegal     = !ctrl.legal;
            S_MEM:   done        = ctrl.is_sw;
            S_WB:    done        = 1'b1;
            default: ;
        endcase
    end

    // Upper address bits and the byte offset are dropped, so addresses wrap.
    assign mem_idx = alu_result_q[MW+1:2];
    assign mem_we  = (state_q == S_MEM) && ctrl.is_sw;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            dmem[mem_idx] <= rt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q         <= '0;
            alu_result_q <= '0;
            zero_q       <= 1'b1;
            mdr_q        <= '0;
        end else begin
            if ((state_q == S_IDLE) && instr_valid) begin
                ir_q <= instr;
            end
            if (state_q == S_EXEC) begin
                alu_result_q <= ctrl.legal ? alu_out : '0;
                zero_q       <= ctrl.legal ? (alu_out == '0) : 1'b1;
            end
            if ((state_q == S_MEM) && ctrl.is_lw) begin
                mdr_q <= dmem[mem_idx];
            end
        end
    end

    assign rf_we    = (state_q == S_WB);
    assign rf_waddr = ctrl.is_rtype ? rd_idx : rt_idx;
    assign rf_wdata = ctrl.is_lw ? mdr_q : alu_result_q;

    assign alu_result = alu_result_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench for multicycle_datapath: stimulus pushes model-predicted
// responses, a monitor pops them on each done/illegal pulse.
module tb_multicycle_datapath;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        done;
    logic        illegal;
    logic [31:0] alu_result;
    logic        zero;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    logic [4:0]  mon_dbg;
    logic [4:0]  stim_dbg;
    bit          stim_owns;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit          ill;
        logic [31:0] alu;
        int          acc;
        int          lat;
        logic [4:0]  dest;
        logic [31:0] oldv;
        logic [31:0] newv;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [64];

    assign dbg_addr = stim_owns ? stim_dbg : mon_dbg;

    multicycle_datapath #(
        .DATA_W     (32),
        .REG_COUNT  (32),
        .DMEM_DEPTH (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .done        (done),
        .illegal     (illegal),
        .alu_result  (alu_result),
        .zero        (zero),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at time %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference model: architectural effect of one instruction, plus the response it should produce.
    task automatic model_push(input logic [31:0] w, input int acc);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] r;
        logic [31:0] wv;
        bit          wr;
        op  = w[31:26];
        rs  = w[25:21];
        rt  = w[20:16];
        rd  = w[15:11];
        fn  = w[5:0];
        imm = {{16{w[15]}}, w[15:0]};
        a   = m_reg[rs];
        b   = m_reg[rt];
        e.ill = 1'b0;
        e.acc = acc;
        e.lat = 2;
        e.dest = rt;
        r  = a + imm;
        wv = 32'h0;
        wr = 1'b1;
        if (op == 6'h00) begin
            e.dest = rd;
            case (fn)
                6'h20:   r = a + b;
                6'h22:   r = a - b;
                6'h24:   r = a & b;
                6'h25:   r = a | b;
                6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: e.ill = 1'b1;
            endcase
            wv = r;
        end else if (op == 6'h08) begin
            wv = r;
        end else if (op == 6'h23) begin
            e.lat = 3;
            wv = m_mem[int'((r >> 2) % 64)];
        end else if (op == 6'h2B) begin
            wr = 1'b0;
            m_mem[int'((r >> 2) % 64)] = b;
        end else begin
            e.ill = 1'b1;
        end
        if (e.ill) begin
            e.alu  = 32'h0;
            e.lat  = 1;
            e.dest = 5'($urandom);
            wr     = 1'b0;
        end else begin
            e.alu = r;
        end
        e.oldv = m_reg[e.dest];
        if (wr && (e.dest != 5'd0)) m_reg[e.dest] = wv;
        e.newv = m_reg[e.dest];
        q.push_back(e);
    endtask

    // Presents w until the DUT is idle; while busy, optionally keeps valid high with junk.
    task automatic issue(input logic [31:0] w, input bit hold);
        bit taken = 1'b0;
        for (int g = 0; g < 50 && !taken; g++) begin
            @(negedge clk);
            if (instr_ready) begin
                instr       = w;
                instr_valid = 1'b1;
                model_push(w, cyc);
                @(posedge clk);
                #1;
                instr_valid = hold;
                instr       = $urandom;
                taken       = 1'b1;
            end else begin
                instr_valid = hold;
                instr       = $urandom;
            end
        end
        if (!taken) begin
            chk("accept_timeout", 32'd0, 32'd1);
            instr_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        instr_valid = 1'b0;
        for (int g = 0; g < 50 && q.size() != 0; g++) @(negedge clk);
        if (q.size() != 0) begin
            chk("drain_pending", 32'(q.size()), 32'd0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic dbg_check(input string name, input logic [4:0] idx, input logic [31:0] exp);
        stim_owns = 1'b1;
        stim_dbg  = idx;
        #1;
        chk(name, dbg_data, exp);
        stim_owns = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fl [5];
        logic [5:0] op;
        logic [5:0] fn;
        int         sel;
        fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25; fl[4] = 6'h2A;
        sel = $urandom_range(0, 11);
        if (sel <= 4) return rtype(5'($urandom), 5'($urandom), 5'($urandom), fl[sel]);
        if (sel <= 6) return itype(6'h08, 5'($urandom), 5'($urandom), 16'($urandom));
        if (sel <= 8) return itype(6'h23, 5'($urandom), 5'($urandom), 16'($urandom));
        if (sel == 9) return itype(6'h2B, 5'($urandom), 5'($urandom), 16'($urandom));
        if (sel == 10) begin
            do op = 6'($urandom); while (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B);
            return {op, 26'($urandom)};
        end
        do fn = 6'($urandom); while (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
        return rtype(5'($urandom), 5'($urandom), 5'($urandom), fn);
    endfunction

    // Monitor: every done/illegal pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        mon_dbg = 5'd0;
        forever begin
            @(negedge clk);
            if (rst_n && (done || illegal)) begin
                if (done && illegal) chk("done_and_illegal", 32'd1, 32'd0);
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, done, illegal}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_is_illegal", {31'd0, illegal}, {31'd0, e.ill});
                    chk("pulse_latency", 32'(cyc - e.acc), 32'(e.lat));
                    mon_dbg = e.dest;
                    #1;
                    chk("dbg_before_write", dbg_data, e.oldv);
                    @(posedge clk);
                    #1;
                    chk("dbg_after_write", dbg_data, e.newv);
                    chk("alu_result", alu_result, e.alu);
                    chk("zero", {31'd0, zero}, {31'd0, (e.alu == 32'h0)});
                    chk("ready_after_pulse", {31'd0, instr_ready}, 32'd1);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        rst_n       = 1'b0;
        instr       = 32'h0;
        instr_valid = 1'b0;
        stim_owns   = 1'b1;
        stim_dbg    = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_alu_result", alu_result, 32'h0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        for (int i = 0; i < 32; i += 7) dbg_check("rst_reg", 5'(i), 32'h0);
        rst_n = 1'b1;
        stim_owns = 1'b0;

        // Reset asserted while an ADDI is in EXEC: it must leave no trace.
        @(negedge clk);
        instr       = itype(6'h08, 5'd0, 5'd1, 16'd5);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, instr_ready}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_zero", {31'd0, zero}, 32'd1);
        chk("midrst_alu_result", alu_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        dbg_check("midrst_r1", 5'd1, 32'h0);
        chk("midrst_idle_ready", {31'd0, instr_ready}, 32'd1);

        issue(itype(6'h08, 5'd0, 5'd1, 16'd5), 1'b0);
        issue(itype(6'h08, 5'd0, 5'd2, 16'hFFFD), 1'b0);
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b0);
        issue(rtype(5'd2, 5'd1, 5'd4, 6'h22), 1'b0);
        issue(rtype(5'd2, 5'd1, 5'd5, 6'h2A), 1'b0);
        issue(itype(6'h2B, 5'd0, 5'd1, 16'h0008), 1'b0);
        issue(itype(6'h23, 5'd0, 5'd6, 16'h0008), 1'b0);
        issue(itype(6'h23, 5'd0, 5'd7, 16'h0108), 1'b0);
        issue(itype(6'h08, 5'd0, 5'd0, 16'd7), 1'b0);
        wait_idle();
        dbg_check("add_r3", 5'd3, 32'd2);
        dbg_check("sub_r4", 5'd4, 32'hFFFF_FFF8);
        dbg_check("slt_r5", 5'd5, 32'd1);
        dbg_check("lw_r6", 5'd6, 32'd5);
        dbg_check("lw_wrap_r7", 5'd7, 32'd5);
        dbg_check("r0_zero", 5'd0, 32'd0);

        issue(itype(6'h08, 5'd0, 5'd9, 16'd1), 1'b0);
        for (int i = 0; i < 31; i++) issue(rtype(5'd9, 5'd9, 5'd9, 6'h20), 1'b0);
        issue(itype(6'h08, 5'd0, 5'd8, 16'hFFFF), 1'b0);
        issue(rtype(5'd9, 5'd8, 5'd1, 6'h20), 1'b0);
        issue(rtype(5'd1, 5'd0, 5'd1, 6'h20), 1'b0);
        issue(itype(6'h08, 5'd1, 5'd1, 16'd1), 1'b0);
        wait_idle();
        dbg_check("wrap_r9", 5'd9, 32'h8000_0000);
        dbg_check("wrap_r1", 5'd1, 32'h8000_0000);

        issue({6'h3F, 26'h0221800}, 1'b0);
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h00), 1'b0);
        issue(itype(6'h23, 5'd0, 5'd10, 16'h0008), 1'b0);
        wait_idle();
        dbg_check("illegal_keeps_r3", 5'd3, 32'd2);
        dbg_check("illegal_keeps_mem", 5'd10, 32'd5);

        issue(itype(6'h08, 5'd0, 5'd11, 16'd100), 1'b1);
        issue(itype(6'h08, 5'd11, 5'd12, 16'hFFFF), 1'b1);
        issue(rtype(5'd11, 5'd12, 5'd13, 6'h20), 1'b1);
        issue(itype(6'h2B, 5'd0, 5'd13, 16'h000C), 1'b1);
        wait_idle();
        dbg_check("held_valid_r13", 5'd13, 32'd199);

        for (int i = 0; i < 16; i++) issue(itype(6'h08, 5'($urandom), 5'($urandom_range(1, 31)), 16'($urandom)), 1'b0);
        for (int w = 0; w < 64; w++) issue(itype(6'h2B, 5'd0, 5'($urandom), 16'(w * 4)), 1'b0);

        for (int i = 0; i < 300; i++) begin
            bit hold;
            hold = 1'($urandom);
            if (!hold) begin
                instr_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            issue(rand_instr(), hold);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
